// File: rtl/page_pkg.sv
// ---------------------------------------------------------------------------
// page_pkg
// Shared definitions for the VGA page switcher:
//   - default page count and pixel width used by the top level
//   - page-select FSM state encoding
//   - page index helpers (wrap-increment, wrap-decrement, range check)
// ---------------------------------------------------------------------------
package page_pkg;

    localparam int DEF_NUM_PAGES = 4;
    localparam int DEF_PIX_W     = 12;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } page_state_e;

    // Next page index, wrapping the last page back to page 0.
    function automatic int unsigned wrap_inc(input int unsigned page,
                                             input int unsigned num_pages);
        if (page >= (num_pages - 32'd1)) begin
            return 32'd0;
        end else begin
            return page + 32'd1;
        end
    endfunction

    // Previous page index, wrapping page 0 back to the last page.
    function automatic int unsigned wrap_dec(input int unsigned page,
                                             input int unsigned num_pages);
        if (page == 32'd0) begin
            return num_pages - 32'd1;
        end else begin
            return page - 32'd1;
        end
    endfunction

    // True when a page index names an existing page.
    function automatic logic page_in_range(input int unsigned page,
                                           input int unsigned num_pages);
        return (page < num_pages);
    endfunction

endpackage

// File: rtl/req_edge_filter.sv
// ---------------------------------------------------------------------------
// req_edge_filter
// Conditions one raw page-request level (key matrix / PS2) for the vga_clk
// domain: 2-FF synchroniser, rising-edge detector and a lockout counter.
//
// Ports:
//   clk        pixel clock
//   rst        synchronous active-high reset
//   req_level  raw asynchronous request level
//   lock_load  parent accepted a request; (re)start the lockout window
//   req_edge   one-cycle pulse on a synchronised rising edge (not gated)
//   lock_busy  lockout window still running
//
// The parent drives the same lock_load into every instance, so all lockout
// counters run in lockstep and behave as one counter shared by the inputs.
// ---------------------------------------------------------------------------
module req_edge_filter #(
    parameter int LOCKOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic req_level,
    input  logic lock_load,
    output logic req_edge,
    output logic lock_busy
);

    localparam int CNT_W = (LOCKOUT_CYC > 0) ? $clog2(LOCKOUT_CYC + 1) : 1;

    logic             sync1_r;
    logic             sync2_r;
    logic             sync3_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchroniser, edge history and lockout countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset high so a key held through reset yields no edge until
            // it is released and pressed again.
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            sync3_r <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= req_level;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            if (lock_load) begin
                cnt_r <= CNT_W'(LOCKOUT_CYC);
            end else if (cnt_r != {CNT_W{1'b0}}) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign req_edge  = sync2_r & ~sync3_r;
    assign lock_busy = (cnt_r != {CNT_W{1'b0}});

endmodule

// File: rtl/page_switcher.sv
// ---------------------------------------------------------------------------
// page_switcher
// Selects one of NUM_PAGES page renderers for the VGA timing block and routes
// matrix-key controls only to the active page. Page changes (next / prev /
// direct select) are held pending and committed only on frame_start, so a
// frame never mixes two pages. Everything runs in the vga_clk domain.
//
// Ports:
//   vga_clk, vga_rst   pixel clock, synchronous active-high reset
//   next_req/prev_req  raw levels; rising edge requests next/previous page
//   sel_valid/sel_page one-cycle direct-select request and its target
//   frame_start        one-cycle pulse at pixel (0,0); commit point
//   ctrl_in/ctrl_out   key vector in; per-page key vectors out (1-cycle)
//   pix_in/pix_out     per-page pixels in; selected pixel out (1-cycle)
//   cur_page           committed page
//   switch_pending     a change is waiting for frame_start
//   page_changed       one-cycle pulse the cycle after a commit
// ---------------------------------------------------------------------------
module page_switcher
    import page_pkg::*;
#(
    parameter  int NUM_PAGES   = DEF_NUM_PAGES,
    parameter  int PIX_W       = DEF_PIX_W,
    parameter  int CTRL_W      = 16,
    parameter  int INIT_PAGE   = 0,
    parameter  int LOCKOUT_CYC = 1024,
    localparam int PAGE_W      = $clog2(NUM_PAGES)
) (
    input  logic                        vga_clk,
    input  logic                        vga_rst,
    input  logic                        next_req,
    input  logic                        prev_req,
    input  logic                        sel_valid,
    input  logic [PAGE_W-1:0]           sel_page,
    input  logic                        frame_start,
    input  logic [CTRL_W-1:0]           ctrl_in,
    output logic [NUM_PAGES*CTRL_W-1:0] ctrl_out,
    input  logic [NUM_PAGES*PIX_W-1:0]  pix_in,
    output logic [PIX_W-1:0]            pix_out,
    output logic [PAGE_W-1:0]           cur_page,
    output logic                        switch_pending,
    output logic                        page_changed
);

    logic                        next_edge_s;
    logic                        prev_edge_s;
    logic                        next_busy_s;
    logic                        prev_busy_s;
    logic                        busy_s;
    logic                        next_acc_s;
    logic                        prev_acc_s;
    logic                        sel_ok_s;
    logic                        lock_load_s;
    logic                        req_valid_s;
    logic [PAGE_W-1:0]           req_target_s;
    logic [PAGE_W-1:0]           base_s;
    logic                        commit_s;
    page_state_e                 state_r;
    page_state_e                 state_nx_s;
    logic [PAGE_W-1:0]           pend_page_r;
    logic [PAGE_W-1:0]           pend_nx_s;
    logic [PAGE_W-1:0]           cur_page_r;
    logic [PAGE_W-1:0]           cur_nx_s;
    logic                        pending_r;
    logic                        changed_r;
    logic [PIX_W-1:0]            pix_out_r;
    logic [NUM_PAGES*CTRL_W-1:0] ctrl_out_r;
    logic [NUM_PAGES*CTRL_W-1:0] ctrl_nx_s;

    req_edge_filter #(
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) u_next_filter (
        .clk       (vga_clk),
        .rst       (vga_rst),
        .req_level (next_req),
        .lock_load (lock_load_s),
        .req_edge  (next_edge_s),
        .lock_busy (next_busy_s)
    );

    req_edge_filter #(
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) u_prev_filter (
        .clk       (vga_clk),
        .rst       (vga_rst),
        .req_level (prev_req),
        .lock_load (lock_load_s),
        .req_edge  (prev_edge_s),
        .lock_busy (prev_busy_s)
    );

    assign busy_s     = next_busy_s | prev_busy_s;
    assign next_acc_s = next_edge_s & ~busy_s;
    assign prev_acc_s = prev_edge_s & ~busy_s;
    assign sel_ok_s   = sel_valid & page_in_range(32'(sel_page), NUM_PAGES);

    // Request decode: direct select beats next/prev; simultaneous next and
    // prev cancel. The lockout is loaded only by a next/prev that actually
    // drives the decode.
    always_comb begin
        base_s       = (state_r == PENDING) ? pend_page_r : cur_page_r;
        req_valid_s  = 1'b0;
        req_target_s = base_s;
        lock_load_s  = 1'b0;
        if (sel_ok_s) begin
            req_valid_s  = 1'b1;
            req_target_s = sel_page;
        end else if (next_acc_s && !prev_acc_s) begin
            req_valid_s  = 1'b1;
            req_target_s = PAGE_W'(wrap_inc(32'(base_s), NUM_PAGES));
            lock_load_s  = 1'b1;
        end else if (prev_acc_s && !next_acc_s) begin
            req_valid_s  = 1'b1;
            req_target_s = PAGE_W'(wrap_dec(32'(base_s), NUM_PAGES));
            lock_load_s  = 1'b1;
        end else begin
            req_valid_s  = 1'b0;
        end
    end

    // Page FSM next-state: retarget while pending, commit on frame_start.
    // In PENDING, base_s is pend_page_r, which is also the page being
    // committed, so a request in the commit cycle is already relative to it.
    always_comb begin
        state_nx_s = state_r;
        pend_nx_s  = pend_page_r;
        cur_nx_s   = cur_page_r;
        commit_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid_s && (req_target_s != cur_page_r)) begin
                    pend_nx_s  = req_target_s;
                    state_nx_s = PENDING;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    commit_s = 1'b1;
                    cur_nx_s = pend_page_r;
                    if (req_valid_s && (req_target_s != pend_page_r)) begin
                        pend_nx_s  = req_target_s;
                        state_nx_s = PENDING;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else if (req_valid_s) begin
                    if (req_target_s == cur_page_r) begin
                        state_nx_s = IDLE;
                    end else begin
                        pend_nx_s  = req_target_s;
                        state_nx_s = PENDING;
                    end
                end else begin
                    state_nx_s = PENDING;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Key routing: only the committed page sees ctrl_in; all slices are
    // blanked in the commit cycle so a held key never reaches both pages.
    always_comb begin
        ctrl_nx_s = {(NUM_PAGES*CTRL_W){1'b0}};
        for (int k = 0; k < NUM_PAGES; k++) begin
            if (!commit_s && (int'(cur_page_r) == k)) begin
                ctrl_nx_s[k*CTRL_W +: CTRL_W] = ctrl_in;
            end else begin
                ctrl_nx_s[k*CTRL_W +: CTRL_W] = {CTRL_W{1'b0}};
            end
        end
    end

    // State, committed page and registered outputs.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            state_r     <= IDLE;
            pend_page_r <= PAGE_W'(INIT_PAGE);
            cur_page_r  <= PAGE_W'(INIT_PAGE);
            pending_r   <= 1'b0;
            changed_r   <= 1'b0;
            pix_out_r   <= {PIX_W{1'b0}};
            ctrl_out_r  <= {(NUM_PAGES*CTRL_W){1'b0}};
        end else begin
            state_r     <= state_nx_s;
            pend_page_r <= pend_nx_s;
            cur_page_r  <= cur_nx_s;
            pending_r   <= (state_nx_s == PENDING);
            changed_r   <= commit_s;
            pix_out_r   <= pix_in[32'(cur_page_r) * PIX_W +: PIX_W];
            ctrl_out_r  <= ctrl_nx_s;
        end
    end

    assign ctrl_out       = ctrl_out_r;
    assign pix_out        = pix_out_r;
    assign cur_page       = cur_page_r;
    assign switch_pending = pending_r;
    assign page_changed   = changed_r;

endmodule

// File: tb/tb_page_switcher.sv
// ---------------------------------------------------------------------------
// tb_page_switcher
// Self-checking bench for page_switcher. A 4-page instance (lockout 16)
// covers the datapath tables and the next/prev/lockout sequences; a 5-page
// instance covers out-of-range direct selects.
// ---------------------------------------------------------------------------
module tb_page_switcher;

    localparam int NP  = 4;
    localparam int NP2 = 5;
    localparam int PW  = 12;
    localparam int CW  = 16;
    localparam int LK  = 16;

    logic vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    logic              vga_rst;
    logic              next_req;
    logic              prev_req;
    logic              sel_valid;
    logic [1:0]        sel_page;
    logic              frame_start;
    logic [CW-1:0]     ctrl_in;
    logic [NP*CW-1:0]  ctrl_out;
    logic [NP*PW-1:0]  pix_in;
    logic [PW-1:0]     pix_out;
    logic [1:0]        cur_page;
    logic              switch_pending;
    logic              page_changed;

    logic              sel2_valid;
    logic [2:0]        sel2_page;
    logic              frame2_start;
    logic [CW-1:0]     ctrl2_in;
    logic [NP2*CW-1:0] ctrl2_out;
    logic [NP2*PW-1:0] pix2_in;
    logic [PW-1:0]     pix2_out;
    logic [2:0]        cur2_page;
    logic              pending2;
    logic              changed2;

    page_switcher #(
        .NUM_PAGES (NP), .PIX_W (PW), .CTRL_W (CW),
        .INIT_PAGE (0), .LOCKOUT_CYC (LK)
    ) u_dut (
        .vga_clk (vga_clk), .vga_rst (vga_rst),
        .next_req (next_req), .prev_req (prev_req),
        .sel_valid (sel_valid), .sel_page (sel_page),
        .frame_start (frame_start),
        .ctrl_in (ctrl_in), .ctrl_out (ctrl_out),
        .pix_in (pix_in), .pix_out (pix_out),
        .cur_page (cur_page), .switch_pending (switch_pending),
        .page_changed (page_changed)
    );

    page_switcher #(
        .NUM_PAGES (NP2), .PIX_W (PW), .CTRL_W (CW),
        .INIT_PAGE (0), .LOCKOUT_CYC (0)
    ) u_dut5 (
        .vga_clk (vga_clk), .vga_rst (vga_rst),
        .next_req (1'b0), .prev_req (1'b0),
        .sel_valid (sel2_valid), .sel_page (sel2_page),
        .frame_start (frame2_start),
        .ctrl_in (ctrl2_in), .ctrl_out (ctrl2_out),
        .pix_in (pix2_in), .pix_out (pix2_out),
        .cur_page (cur2_page), .switch_pending (pending2),
        .page_changed (changed2)
    );

    typedef struct {
        logic [NP*PW-1:0] pix;
        logic [CW-1:0]    ctrl;
        logic [PW-1:0]    exp_pix;
        logic [NP*CW-1:0] exp_ctrl;
    } vec_t;

    typedef struct {
        logic [PW-1:0]    pix;
        logic [NP*CW-1:0] ctrl;
    } sb_t;

    vec_t vecs [8];
    sb_t  sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [79:0] act,
                         input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    // Drive table rows on a stable page; expectations go through a queue and
    // are compared when the registered outputs appear one cycle later.
    task automatic run_vecs(input int lo, input int hi);
        sb_t e;
        for (int i = lo; i <= hi; i++) begin
            pix_in  = vecs[i].pix;
            ctrl_in = vecs[i].ctrl;
            sb_q.push_back('{vecs[i].exp_pix, vecs[i].exp_ctrl});
            tick();
            e = sb_q.pop_front();
            check($sformatf("vec%0d_pix", i), 80'(pix_out), 80'(e.pix));
            check($sformatf("vec%0d_ctrl", i), 80'(ctrl_out), 80'(e.ctrl));
        end
    endtask

    task automatic press_next();
        next_req = 1'b1; wait_cyc(2);
        next_req = 1'b0; wait_cyc(2);
    endtask

    task automatic press_prev();
        prev_req = 1'b1; wait_cyc(2);
        prev_req = 1'b0; wait_cyc(2);
    endtask

    task automatic do_sel(input logic [1:0] p);
        sel_valid = 1'b1; sel_page = p; tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_frame();
        frame_start = 1'b1; tick();
        frame_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_bad;

        // page 0 rows
        vecs[0] = '{48'h444_333_222_111, 16'h0001, 12'h111, 64'h0000_0000_0000_0001};
        vecs[1] = '{48'hFFF_EEE_DDD_ABC, 16'hA5A5, 12'hABC, 64'h0000_0000_0000_A5A5};
        vecs[2] = '{48'h000_000_000_FFF, 16'hFFFF, 12'hFFF, 64'h0000_0000_0000_FFFF};
        vecs[3] = '{48'h123_456_789_000, 16'h0000, 12'h000, 64'h0000_0000_0000_0000};
        // page 1 rows
        vecs[4] = '{48'h444_333_222_111, 16'h8001, 12'h222, 64'h0000_0000_8001_0000};
        vecs[5] = '{48'hFFF_EEE_DDD_ABC, 16'h5A5A, 12'hDDD, 64'h0000_0000_5A5A_0000};
        vecs[6] = '{48'h000_000_7E7_000, 16'hFFFF, 12'h7E7, 64'h0000_0000_FFFF_0000};
        vecs[7] = '{48'hFFF_FFF_000_FFF, 16'h0F0F, 12'h000, 64'h0000_0000_0F0F_0000};

        vga_rst = 1'b1; next_req = 1'b1; prev_req = 1'b0;
        sel_valid = 1'b0; sel_page = 2'd0; frame_start = 1'b0;
        ctrl_in = 16'hFFFF; pix_in = 48'hFFF_FFF_FFF_FFF;
        sel2_valid = 1'b0; sel2_page = 3'd0; frame2_start = 1'b0;
        ctrl2_in = 16'h1234; pix2_in = 60'h555_444_333_222_111;

        // Reset with next_req held high
        wait_cyc(3);
        check("rst_cur", 80'(cur_page), 80'd0);
        check("rst_pix", 80'(pix_out), 80'd0);
        check("rst_ctrl", 80'(ctrl_out), 80'd0);
        check("rst_pend", 80'(switch_pending), 80'd0);
        check("rst_chg", 80'(page_changed), 80'd0);
        check("rst5_pix", 80'(pix2_out), 80'd0);

        pix_in = 48'h0; ctrl_in = 16'h0; vga_rst = 1'b0;
        saw_bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (switch_pending || (cur_page != 2'd0)) saw_bad = 1'b1;
        end
        check("held_no_switch", 80'(saw_bad), 80'd0);
        check("held_cur", 80'(cur_page), 80'd0);
        check("held_pix", 80'(pix_out), 80'd0);
        check("d5_pix", 80'(pix2_out), 80'h111);
        check("d5_ctrl", 80'(ctrl2_out), 80'h1234);
        next_req = 1'b0;
        wait_cyc(4);

        run_vecs(0, 3);

        // Next edge at cycle 10, frame_start at cycle 100
        pix_in = 48'h444_333_222_111; ctrl_in = 16'hBEEF;
        for (int c = 0; c <= 105; c++) begin
            if (c == 12) check("t2_pend_c12", 80'(switch_pending), 80'd0);
            if (c == 13) check("t2_pend_c13", 80'(switch_pending), 80'd1);
            if (c == 100) begin
                check("t2_pend_c100", 80'(switch_pending), 80'd1);
                check("t2_cur_c100", 80'(cur_page), 80'd0);
                check("t2_chg_c100", 80'(page_changed), 80'd0);
            end
            if (c == 101) begin
                check("t2_pend_c101", 80'(switch_pending), 80'd0);
                check("t2_cur_c101", 80'(cur_page), 80'd1);
                check("t2_chg_c101", 80'(page_changed), 80'd1);
                check("t2_pix_c101", 80'(pix_out), 80'h111);
                check("t2_ctrl_blank", 80'(ctrl_out), 80'd0);
            end
            if (c == 102) begin
                check("t2_chg_c102", 80'(page_changed), 80'd0);
                check("t2_pix_c102", 80'(pix_out), 80'h222);
                check("t2_ctrl_c102", 80'(ctrl_out), 80'h0000_0000_BEEF_0000);
            end
            next_req    = (c == 10) || (c == 11);
            frame_start = (c == 100);
            tick();
        end

        run_vecs(4, 7);

        // Wrap: 3 -> next -> 0, 0 -> prev -> 3
        do_sel(2'd3);
        tick();
        check("sel3_pend", 80'(switch_pending), 80'd1);
        do_frame();
        check("sel3_cur", 80'(cur_page), 80'd3);
        press_next();
        check("wrapn_pend", 80'(switch_pending), 80'd1);
        do_frame();
        check("wrapn_cur", 80'(cur_page), 80'd0);
        wait_cyc(20);
        press_prev();
        check("wrapp_pend", 80'(switch_pending), 80'd1);
        do_frame();
        check("wrapp_cur", 80'(cur_page), 80'd3);
        wait_cyc(20);

        // Simultaneous next and prev cancel and leave the lockout idle
        next_req = 1'b1; prev_req = 1'b1; wait_cyc(2);
        next_req = 1'b0; prev_req = 1'b0; wait_cyc(3);
        check("cancel_pend", 80'(switch_pending), 80'd0);
        press_next();
        check("after_cancel_pend", 80'(switch_pending), 80'd1);
        do_frame();
        check("after_cancel_cur", 80'(cur_page), 80'd0);
        wait_cyc(20);

        // Lockout: second edge 8 cycles later is dropped
        press_next();
        wait_cyc(4);
        press_next();
        wait_cyc(2);
        check("lock_pend", 80'(switch_pending), 80'd1);
        do_frame();
        check("lock_cur", 80'(cur_page), 80'd1);

        // Out-of-range direct selects on the 5-page instance
        sel2_valid = 1'b1; sel2_page = 3'd2; tick(); sel2_valid = 1'b0;
        check("d5_sel2_pend", 80'(pending2), 80'd1);
        sel2_valid = 1'b1; sel2_page = 3'd5; tick(); sel2_valid = 1'b0;
        check("d5_sel5_pend", 80'(pending2), 80'd1);
        sel2_valid = 1'b1; sel2_page = 3'd0; tick(); sel2_valid = 1'b0;
        check("d5_sel0_pend", 80'(pending2), 80'd0);
        frame2_start = 1'b1; tick(); frame2_start = 1'b0;
        check("d5_nocommit_cur", 80'(cur2_page), 80'd0);
        check("d5_nocommit_chg", 80'(changed2), 80'd0);
        sel2_valid = 1'b1; sel2_page = 3'd7; tick(); sel2_valid = 1'b0;
        check("d5_sel7_pend", 80'(pending2), 80'd0);
        sel2_valid = 1'b1; sel2_page = 3'd4; tick(); sel2_valid = 1'b0;
        check("d5_sel4_pend", 80'(pending2), 80'd1);
        frame2_start = 1'b1; tick(); frame2_start = 1'b0;
        check("d5_sel4_cur", 80'(cur2_page), 80'd4);
        check("d5_sel4_chg", 80'(changed2), 80'd1);
        tick();
        check("d5_pix4", 80'(pix2_out), 80'h555);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
